// File: rtl/bcd_display_scan.sv
// Multiplexed BCD 7-segment scanner: one digit slot per SCAN_DIV clocks, dark lead-in per slot.
// Define BCD_DISPLAY_BLANK_LZ_EN to blank leading zeros (slot 0 always shown).
`timescale 1ns/1ps

package bcd_display_scan_pkg;
  typedef logic [3:0] BCDnumber_t;
  typedef enum logic {BLANK, DRIVE} state_t;
endpackage

module bcd_display_scan
  import bcd_display_scan_pkg::*;
#(
  parameter int DEC       = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  BCDnumber_t [DEC-1:0]   digit,
  output logic       [DEC-1:0]   an,
  output logic       [6:0]       seg,
  output logic                   frame
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DEC > 1) ? $clog2(DEC) : 1;

  // presc/idx name the position the next edge will present, so the first
  // edge after reset presents slot 0, cycle 0 (frame start).
  logic       [PW-1:0] presc;
  logic       [IW-1:0] idx;
  state_t              state;
  BCDnumber_t [DEC-1:0] shadow;

  logic slot_wrap;
  logic frame_start;
  logic lz_blank;

  function automatic logic [6:0] decode(input BCDnumber_t v);
    case (v)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  assign slot_wrap   = (presc == PW'(SCAN_DIV - 1));
  assign frame_start = (presc == '0) && (idx == '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    lz_blank = 1'b0;
`ifdef BCD_DISPLAY_BLANK_LZ_EN
    if (idx != '0) begin
      lz_blank = 1'b1;
      for (int i = 0; i < DEC; i++) begin
        if ((i >= int'(idx)) && (shadow[i] != '0)) lz_blank = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc  <= '0;
      idx    <= '0;
      state  <= BLANK;
      // NOTE: the shadow bank is reset too, so blanking logic never sees X before the first capture.
      shadow <= '0;
      an     <= '1;
      seg    <= 7'h7F;
      frame  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      frame <= frame_start;
      if (frame_start) shadow <= digit;

      if (presc < PW'(BLANK_CYC)) begin
        state <= BLANK;
        an    <= '1;
        seg   <= 7'h7F;
      end else begin
        state <= DRIVE;
        if (lz_blank) begin
          an  <= '1;
          seg <= 7'h7F;
        end else begin
          an  <= ~(DEC'(1) << idx);
          seg <= decode(shadow[idx]);
        end
      end

      if (slot_wrap) begin
        presc <= '0;
        idx   <= (idx == IW'(DEC - 1)) ? '0 : idx + IW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  a_an_onehot0 : assert property (@(posedge clk) disable iff (!rst) $onehot0(~an));
  a_blank_dark : assert property (@(posedge clk) disable iff (!rst) (state == BLANK) |-> (an == '1));

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan (DEC=4, SCAN_DIV=8, BLANK_CYC=2): expected per-cycle
// an/seg/frame are queued by the stimulus and popped by a negedge monitor.
`timescale 1ns/1ps

module tb_bcd_display_scan;
  import bcd_display_scan_pkg::*;

  localparam int DEC       = 4;
  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  BCDnumber_t [DEC-1:0] digit;
  logic       [DEC-1:0] an;
  logic       [6:0]     seg;
  logic                 frame;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  bcd_display_scan #(.DEC(DEC), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk   (clk),
    .rst   (rst),
    .digit (digit),
    .an    (an),
    .seg   (seg),
    .frame (frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: seg_of = 7'h40;  4'd1: seg_of = 7'h79;
      4'd2: seg_of = 7'h24;  4'd3: seg_of = 7'h30;
      4'd4: seg_of = 7'h19;  4'd5: seg_of = 7'h12;
      4'd6: seg_of = 7'h02;  4'd7: seg_of = 7'h78;
      4'd8: seg_of = 7'h00;  4'd9: seg_of = 7'h10;
      default: seg_of = 7'h3F;
    endcase
  endfunction

  // d is written msd..lsd as hex, e.g. 16'h1234 -> slot 0 shows 4
  task automatic push_frame(input logic [15:0] d);
    for (int s = 0; s < DEC; s++) begin
      logic [3:0] nib;
      logic       lz;
      nib = d[4*s +: 4];
      lz  = 1'b0;
`ifdef BCD_DISPLAY_BLANK_LZ_EN
      lz = (s > 0) && ((d >> (4*s)) == 16'h0);
`endif
      for (int c = 0; c < SCAN_DIV; c++) begin
        exp_t e;
        if (c < BLANK_CYC || lz) begin
          e.an = 4'hF; e.seg = 7'h7F;
        end else begin
          e.an = ~(4'b0001 << s); e.seg = seg_of(nib);
        end
        e.frame = (s == 0) && (c == 0);
        q.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    check("an_onehot0", {31'b0, $onehot0(~an)}, 32'd1);
    if (mon_en) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got empty queue, required an entry at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("scan_an_seg_frame", {20'b0, an, seg, frame}, {20'b0, e});
      end
    end
  end

  task automatic drain(input string name);
    for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
    check(name, q.size(), 0);
    mon_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b0;
    digit = 16'h1234;
    repeat (3) @(negedge clk);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_frame", frame, 1'b0);

    // frames 0,1: 1234 (digit changes mid-frame 1); frame 2: 5678; frame 3: 00A7
    push_frame(16'h1234);
    push_frame(16'h1234);
    push_frame(16'h5678);
    push_frame(16'h00A7);

    rst = 1'b1;
    @(posedge clk);
    mon_en = 1'b1;
    #1 check("first_frame_pulse", frame, 1'b1);

    repeat (42) @(negedge clk);
    digit = 16'h5678;
    repeat (38) @(negedge clk);
    digit = 16'h00A7;
    repeat (24) @(negedge clk);
    digit = 16'h1234;
    drain("drain_main");

    // now just past the edge presenting frame 4 cycle 0; step into slot 2 DRIVE
    repeat (19) @(negedge clk);
    check("slot2_an", an, 4'hB);
    check("slot2_seg", seg, 7'h24);
    #2 rst = 1'b0;
    #1;
    check("async_rst_an", an, 4'hF);
    check("async_rst_seg", seg, 7'h7F);
    check("async_rst_frame", frame, 1'b0);

    push_frame(16'h1234);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    mon_en = 1'b1;
    #1 check("restart_frame_pulse", frame, 1'b1);
    drain("drain_restart");

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_display_scan.md
BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 The module SHALL have parameter DEC, default 4, meaning the number of BCD digits scanned.
REQ-002 The module SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles per digit slot; legal range is SCAN_DIV >= BLANK_CYC+2.
REQ-003 The module SHALL have parameter BLANK_CYC, default 2, meaning anti-ghosting dark cycles at the start of each slot; legal range is BLANK_CYC >= 1.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  SHALL be the reset, asynchronous and active-low.
REQ-006 digit  input  BCDnumber_t [DEC-1:0]  SHALL carry the BCD value per digit from .digito; index 0 is the least significant digit.
REQ-007 an  output  DEC  SHALL be the digit enables, active-low, and at most one bit SHALL be low at any time.
REQ-008 seg  output  7  SHALL be the segments, active-low, with seg[0]=a through seg[6]=g.
REQ-009 frame  output  1  SHALL be a one-cycle pulse marking frame start.

Function
REQ-010 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; each wrap SHALL end the current slot.
REQ-011 The FSM SHALL be two-state: BLANK (prescaler < BLANK_CYC) then DRIVE (remaining SCAN_DIV-BLANK_CYC cycles).
REQ-012 The slot index idx SHALL run 0..DEC-1 and SHALL advance on prescaler wrap, wrapping DEC-1 -> 0.
REQ-013 When entering BLANK with idx=0, a shadow register SHALL capture all digit inputs in that same cycle, and frame SHALL be 1 for exactly that cycle.
REQ-014 The shadow register SHALL be held constant for the rest of the frame; input changes mid-frame SHALL NOT affect displayed values.
REQ-015 In BLANK, an SHALL be all ones and seg SHALL be 7'h7F.
REQ-016 In DRIVE, an SHALL have only bit idx low and seg SHALL be the decode of shadow[idx].
REQ-017 Decode values 0-9 SHALL be 40,79,24,30,19,12,02,78,00,10 (hex, bits g..a).
REQ-018 Codes 10-15 SHALL display a dash: seg=7'h3F.
REQ-019 an and seg SHALL be registered and SHALL change on the same edge as the FSM/idx transition, with no combinational path from digit.
REQ-020 The FSM SHALL have no stall or handshake; scanning SHALL be free-running.

Reset
REQ-021 While rst=0: prescaler=0, idx=0, state=BLANK, shadow=0, an all ones, seg=7'h7F, frame=0.
REQ-022 On the first rising edge after rst rises, the block SHALL start frame 0 per REQ-013 with frame=1.
REQ-023 Reset asserted mid-slot SHALL force reset values immediately, without waiting for clk.

Configuration
REQ-024 Macro BCD_DISPLAY_BLANK_LZ_EN, when defined, SHALL enable leading-zero blanking.
REQ-025 With the macro, slot i>0 SHALL remain dark (an all ones, seg 7'h7F) in DRIVE when shadow[DEC-1..i] are all zero; slot 0 SHALL never be blanked.
REQ-026 Without the macro, every slot SHALL be driven and zeros SHALL show as 7'h40.
REQ-027 Slot timing, idx sequence and frame SHALL be identical in both builds.

Verification (DEC=4, SCAN_DIV=8, BLANK_CYC=2)
REQ-028 Reset check: rst=0 for 3 cycles -> an=4'hF, seg=7'h7F, frame=0; first edge after release -> frame=1.
REQ-029 Scan order: digit={1,2,3,4} (msd..lsd) -> slots show 7'h19, 30, 24, 79 at an=E,D,B,7; each slot is 2 dark + 6 driven cycles; frame period is 32 cycles.
REQ-030 Tearing: change digit from 1234 to 5678 at cycle 10 of a frame -> rest of frame still shows 1234; next frame shows 5678.
REQ-031 Invalid and zero: digit={0,0,0xA,7} -> slot 1 seg=7'h3F, slot 0 seg=7'h78; slots 3 and 2 are dark with the macro and show 7'h40 without it.
REQ-032 Mid-slot reset: assert rst during DRIVE of slot 2 -> an=4'hF asynchronously; after release, scan restarts at idx 0 with frame=1.
REQ-033 Assertion: at most one an bit is low at any time, and an is all ones whenever the FSM is in BLANK, across the whole run.
